// File: rtl/noc_local_ni_if.sv
// noc_local_ni_if: bundle of every handshake/data signal between the local network
// interface, its processing core and the router L port.
//   Injection (core -> NI):   inj_valid, inj_ready, inj_dst_x, inj_dst_y, inj_data
//   Transmit  (NI -> router): tx_flit, tx_valid, tx_ready
//   Receive   (router -> NI): rx_flit, rx_valid, rx_ready
//   Ejection  (NI -> core):   ej_valid, ej_ready, ej_src_x, ej_src_y, ej_seq, ej_data
//   Status:                   err (one-cycle error pulse)
// Modport slave is the NI side; modport master is the core/router side.
interface noc_local_ni_if #(
   parameter int unsigned DATA_W        = 32,
   parameter int unsigned PAYLOAD_FLITS = 2
);
   localparam int unsigned FLIT_W = DATA_W + 2;
   localparam int unsigned PAY_W  = PAYLOAD_FLITS * DATA_W;

   logic              inj_valid;
   logic              inj_ready;
   logic [1:0]        inj_dst_x;
   logic [1:0]        inj_dst_y;
   logic [PAY_W-1:0]  inj_data;
   logic [FLIT_W-1:0] tx_flit;
   logic              tx_valid;
   logic              tx_ready;
   logic [FLIT_W-1:0] rx_flit;
   logic              rx_valid;
   logic              rx_ready;
   logic              ej_valid;
   logic              ej_ready;
   logic [1:0]        ej_src_x;
   logic [1:0]        ej_src_y;
   logic [7:0]        ej_seq;
   logic [PAY_W-1:0]  ej_data;
   logic              err;

   modport slave (
      input  inj_valid, inj_dst_x, inj_dst_y, inj_data, tx_ready, rx_flit, rx_valid, ej_ready,
      output inj_ready, tx_flit, tx_valid, rx_ready, ej_valid, ej_src_x, ej_src_y, ej_seq,
             ej_data, err
   );

   modport master (
      output inj_valid, inj_dst_x, inj_dst_y, inj_data, tx_ready, rx_flit, rx_valid, ej_ready,
      input  inj_ready, tx_flit, tx_valid, rx_ready, ej_valid, ej_src_x, ej_src_y, ej_seq,
             ej_data, err
   );
endinterface

// File: rtl/noc_local_ni.sv
// noc_local_ni: network interface on the local port of a mesh node.
// Injection serialises one core message into a head flit plus PAYLOAD_FLITS body flits
// (last one typed tail). Ejection checks the destination of incoming packets, reassembles
// the payload and holds it for the core under valid/ready.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - noc_local_ni_if.slave: inj_* (core in), tx_* (router in), rx_* (router out),
//          ej_* (core out), err (registered one-cycle error pulse)
module noc_local_ni #(
   parameter int unsigned XCOORD        = 0,
   parameter int unsigned YCOORD        = 0,
   parameter int unsigned DATA_W        = 32,
   parameter int unsigned PAYLOAD_FLITS = 2,
   parameter int unsigned FLIT_W        = DATA_W + 2
) (
   input logic           clk,
   input logic           rst,
   noc_local_ni_if.slave bus
);

   localparam int unsigned PayW    = PAYLOAD_FLITS * DATA_W;
   localparam int unsigned CntW    = (PAYLOAD_FLITS > 1) ? $clog2(PAYLOAD_FLITS) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(PAYLOAD_FLITS - 1);
   localparam logic [1:0] TypeHead = 2'b10;
   localparam logic [1:0] TypeBody = 2'b00;
   localparam logic [1:0] TypeTail = 2'b01;
   localparam logic [1:0] OwnX     = 2'(XCOORD);
   localparam logic [1:0] OwnY     = 2'(YCOORD);

   // ---------------------------------------------------------------- injection / TX
   typedef enum logic [1:0] {TxIdle, TxHead, TxBody} tx_state_e;

   tx_state_e         tx_state_q, tx_state_d;
   logic [1:0]        tx_dst_x_q, tx_dst_x_d;
   logic [1:0]        tx_dst_y_q, tx_dst_y_d;
   logic [PayW-1:0]   tx_data_q, tx_data_d;
   logic [CntW-1:0]   tx_cnt_q, tx_cnt_d;
   logic [7:0]        tx_seq_q, tx_seq_d;
   logic [DATA_W-1:0] tx_word;
   logic [DATA_W-1:0] tx_head;
   logic [FLIT_W-1:0] tx_flit;
   logic              tx_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state_q <= TxIdle;
         tx_dst_x_q <= '0;
         tx_dst_y_q <= '0;
         tx_data_q  <= '0;
         tx_cnt_q   <= '0;
         tx_seq_q   <= '0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_dst_x_q <= tx_dst_x_d;
         tx_dst_y_q <= tx_dst_y_d;
         tx_data_q  <= tx_data_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_seq_q   <= tx_seq_d;
      end
   end

   // Flit contents derive only from registers, so they stay stable while stalled.
   always_comb begin
      tx_state_d = tx_state_q;
      tx_dst_x_d = tx_dst_x_q;
      tx_dst_y_d = tx_dst_y_q;
      tx_data_d  = tx_data_q;
      tx_cnt_d   = tx_cnt_q;
      tx_seq_d   = tx_seq_q;
      tx_valid   = 1'b0;
      tx_flit    = '0;
      tx_word    = tx_data_q[int'(tx_cnt_q) * DATA_W +: DATA_W];
      tx_head    = '0;
      tx_head[15:0] = {tx_dst_x_q, tx_dst_y_q, OwnX, OwnY, tx_seq_q};
      unique case (tx_state_q)
         TxIdle: begin
            if (bus.inj_valid) begin
               tx_dst_x_d = bus.inj_dst_x;
               tx_dst_y_d = bus.inj_dst_y;
               tx_data_d  = bus.inj_data;
               tx_state_d = TxHead;
            end
         end
         TxHead: begin
            tx_valid = 1'b1;
            tx_flit  = {TypeHead, tx_head};
            if (bus.tx_ready) begin
               tx_cnt_d   = '0;
               tx_state_d = TxBody;
            end
         end
         TxBody: begin
            tx_valid = 1'b1;
            tx_flit  = {(tx_cnt_q == LastCnt) ? TypeTail : TypeBody, tx_word};
            if (bus.tx_ready) begin
               if (tx_cnt_q == LastCnt) begin
                  tx_seq_d   = tx_seq_q + 8'd1;
                  tx_state_d = TxIdle;
               end else begin
                  tx_cnt_d = tx_cnt_q + CntW'(1);
               end
            end
         end
         default: tx_state_d = TxIdle;
      endcase
   end

   assign bus.inj_ready = (tx_state_q == TxIdle);
   assign bus.tx_valid  = tx_valid;
   assign bus.tx_flit   = tx_flit;

   // ---------------------------------------------------------------- ejection / RX
   typedef enum logic [1:0] {RxHead, RxBody, RxHold, RxDrop} rx_state_e;

   rx_state_e         rx_state_q, rx_state_d;
   logic [CntW-1:0]   rx_cnt_q, rx_cnt_d;
   logic [1:0]        src_x_q, src_x_d;
   logic [1:0]        src_y_q, src_y_d;
   logic [7:0]        seq_q, seq_d;
   logic [PayW-1:0]   rx_data_q, rx_data_d;
   logic              err_q, err_d;
   logic              rx_ready;
   logic              rx_hs;
   logic [1:0]        rx_type;
   logic [DATA_W-1:0] rx_word;

   assign rx_ready = (rx_state_q != RxHold);
   assign rx_hs    = bus.rx_valid && rx_ready;
   assign rx_type  = bus.rx_flit[FLIT_W-1 -: 2];
   assign rx_word  = bus.rx_flit[DATA_W-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_state_q <= RxHead;
         rx_cnt_q   <= '0;
         src_x_q    <= '0;
         src_y_q    <= '0;
         seq_q      <= '0;
         rx_data_q  <= '0;
         err_q      <= 1'b0;
      end else begin
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         src_x_q    <= src_x_d;
         src_y_q    <= src_y_d;
         seq_q      <= seq_d;
         rx_data_q  <= rx_data_d;
         err_q      <= err_d;
      end
   end

   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      src_x_d    = src_x_q;
      src_y_d    = src_y_q;
      seq_d      = seq_q;
      rx_data_d  = rx_data_q;
      err_d      = 1'b0;
      unique case (rx_state_q)
         RxHead: begin
            if (rx_hs) begin
               if (rx_type == TypeHead) begin
                  if (rx_word[15:14] == OwnX && rx_word[13:12] == OwnY) begin
                     src_x_d    = rx_word[11:10];
                     src_y_d    = rx_word[9:8];
                     seq_d      = rx_word[7:0];
                     rx_cnt_d   = '0;
                     rx_state_d = RxBody;
                  end else begin
                     err_d      = 1'b1;
                     rx_state_d = RxDrop;
                  end
               end else begin
                  // Orphan body/tail: flag and discard, stay waiting for a head.
                  err_d = 1'b1;
               end
            end
         end
         RxBody: begin
            if (rx_hs) begin
               if (rx_type == TypeTail) begin
                  if (rx_cnt_q == LastCnt) begin
                     rx_data_d[int'(rx_cnt_q) * DATA_W +: DATA_W] = rx_word;
                     rx_state_d = RxHold;
                  end else begin
                     err_d      = 1'b1;
                     rx_state_d = RxHead;
                  end
               end else if (rx_type == TypeBody && rx_cnt_q != LastCnt) begin
                  rx_data_d[int'(rx_cnt_q) * DATA_W +: DATA_W] = rx_word;
                  rx_cnt_d = rx_cnt_q + CntW'(1);
               end else begin
                  // Overlength body, unexpected head or undefined type: drop the rest.
                  err_d      = 1'b1;
                  rx_state_d = RxDrop;
               end
            end
         end
         RxHold: begin
            if (bus.ej_ready) rx_state_d = RxHead;
         end
         RxDrop: begin
            if (rx_hs && rx_type == TypeTail) rx_state_d = RxHead;
         end
         default: rx_state_d = RxHead;
      endcase
   end

   assign bus.rx_ready = rx_ready;
   assign bus.ej_valid = (rx_state_q == RxHold);
   assign bus.ej_src_x = src_x_q;
   assign bus.ej_src_y = src_y_q;
   assign bus.ej_seq   = seq_q;
   assign bus.ej_data  = rx_data_q;
   assign bus.err      = err_q;

endmodule

// File: tb/tb_noc_local_ni.sv
// Bench for noc_local_ni at node (1,2) with two 32-bit body flits per packet.
module tb_noc_local_ni;
   localparam int unsigned DW = 32;
   localparam int unsigned PF = 2;
   localparam int unsigned FW = DW + 2;
   localparam int unsigned PW = PF * DW;
   localparam logic [1:0]  MX = 2'd1;
   localparam logic [1:0]  MY = 2'd2;

   typedef struct {
      logic [FW-1:0] flit;
      bit            err;
      bit            good_end;
   } rx_item_t;

   typedef struct {
      logic [1:0]    sx;
      logic [1:0]    sy;
      logic [7:0]    seq;
      logic [PW-1:0] data;
   } msg_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   noc_local_ni_if #(.DATA_W(DW), .PAYLOAD_FLITS(PF)) bus ();

   noc_local_ni #(
      .XCOORD(1), .YCOORD(2), .DATA_W(DW), .PAYLOAD_FLITS(PF)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------- reference model
   logic [FW-1:0] tx_q[$];
   logic [7:0]    seq_m = '0;
   rx_item_t      rx_q[$];
   msg_t          msg_q[$];
   bit            ej_pend  = 1'b0;
   bit            err_pend = 1'b0;
   bit            rx_hs    = 1'b0;
   int            err_seen = 0;

   function automatic logic [FW-1:0] head_flit(input logic [1:0] dx, input logic [1:0] dy,
                                                input logic [1:0] sx, input logic [1:0] sy,
                                                input logic [7:0] sq);
      logic [DW-1:0] d;
      d = '0;
      d[15:0] = {dx, dy, sx, sy, sq};
      return {2'b10, d};
   endfunction

   // Compare everything mid-cycle, then advance the model by the handshakes that the
   // coming edge will perform.
   initial begin
      rx_item_t it;
      @(posedge clk);
      forever begin
         @(negedge clk);
         chk("inj_ready", bus.inj_ready, tx_q.size() == 0);
         chk("tx_valid", bus.tx_valid, tx_q.size() != 0);
         if (tx_q.size() != 0) chk("tx_flit", bus.tx_flit, tx_q[0]);
         chk("rx_ready", bus.rx_ready, !ej_pend);
         chk("ej_valid", bus.ej_valid, ej_pend);
         if (ej_pend && msg_q.size() != 0) begin
            chk("ej_src_x", bus.ej_src_x, msg_q[0].sx);
            chk("ej_src_y", bus.ej_src_y, msg_q[0].sy);
            chk("ej_seq", bus.ej_seq, msg_q[0].seq);
            chk("ej_data", bus.ej_data, msg_q[0].data);
         end
         chk("err", bus.err, err_pend);
         if (bus.err) err_seen++;
         if (rst) begin
            tx_q.delete();
            seq_m = '0;
            if (ej_pend && msg_q.size() != 0) msg_q.delete(0);
            ej_pend  = 1'b0;
            err_pend = 1'b0;
         end else begin
            if (bus.tx_valid && bus.tx_ready && tx_q.size() != 0) tx_q.delete(0);
            if (bus.inj_valid && bus.inj_ready) begin
               tx_q.push_back(head_flit(bus.inj_dst_x, bus.inj_dst_y, MX, MY, seq_m));
               for (int w = 0; w < PF; w++)
                  tx_q.push_back({(w == PF - 1) ? 2'b01 : 2'b00, bus.inj_data[w*DW +: DW]});
               seq_m = seq_m + 8'd1;
            end
            if (bus.ej_valid && bus.ej_ready && ej_pend) begin
               if (msg_q.size() != 0) msg_q.delete(0);
               ej_pend = 1'b0;
            end
            err_pend = 1'b0;
            if (bus.rx_valid && bus.rx_ready && rx_q.size() != 0) begin
               it = rx_q.pop_front();
               err_pend = it.err;
               if (it.good_end) ej_pend = 1'b1;
               rx_hs = 1'b1;
            end
         end
      end
   end

   // ---------------------------------------------------------------- drivers
   int tx_mode = 2;   // 0 random, 1 low, 2 high
   int ej_mode = 2;
   bit rx_gaps = 1'b0;

   initial begin
      bus.inj_valid = 1'b0;
      bus.inj_dst_x = '0;
      bus.inj_dst_y = '0;
      bus.inj_data  = '0;
      bus.tx_ready  = 1'b1;
      bus.rx_valid  = 1'b0;
      bus.rx_flit   = '0;
      bus.ej_ready  = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         bus.tx_ready = (tx_mode == 0) ? 1'($urandom_range(0, 1)) : (tx_mode == 2);
         bus.ej_ready = (ej_mode == 0) ? 1'($urandom_range(0, 1)) : (ej_mode == 2);
         if (rx_hs) begin
            bus.rx_valid = 1'b0;
            rx_hs = 1'b0;
         end
         if (!bus.rx_valid && rx_q.size() != 0 && (!rx_gaps || $urandom_range(0, 2) != 0)) begin
            bus.rx_valid = 1'b1;
            bus.rx_flit  = rx_q[0].flit;
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   task automatic inject(input logic [1:0] dx, input logic [1:0] dy, input logic [PW-1:0] d);
      int cyc = 0;
      @(posedge clk);
      #1;
      bus.inj_valid = 1'b1;
      bus.inj_dst_x = dx;
      bus.inj_dst_y = dy;
      bus.inj_data  = d;
      do begin
         @(negedge clk);
         cyc++;
      end while (!bus.inj_ready && cyc < 200);
      chk("inject_timeout", cyc < 200, 1'b1);
      @(posedge clk);
      #1;
      bus.inj_valid = 1'b0;
   endtask

   task automatic push_item(input logic [FW-1:0] f, input bit e, input bit g);
      rx_item_t it;
      it.flit = f;
      it.err = e;
      it.good_end = g;
      rx_q.push_back(it);
   endtask

   task automatic push_good(input logic [1:0] sx, input logic [1:0] sy, input logic [7:0] sq,
                            input logic [PW-1:0] d);
      msg_t m;
      m.sx = sx;
      m.sy = sy;
      m.seq = sq;
      m.data = d;
      msg_q.push_back(m);
      push_item(head_flit(MX, MY, sx, sy, sq), 1'b0, 1'b0);
      push_item({2'b00, d[DW-1:0]}, 1'b0, 1'b0);
      push_item({2'b01, d[2*DW-1:DW]}, 1'b0, 1'b1);
   endtask

   task automatic push_misroute();
      logic [1:0] dx, dy;
      do begin
         dx = 2'($urandom_range(0, 3));
         dy = 2'($urandom_range(0, 3));
      end while (dx == MX && dy == MY);
      push_item(head_flit(dx, dy, 2'd0, 2'd0, 8'($urandom)), 1'b1, 1'b0);
      push_item({2'b00, DW'($urandom)}, 1'b0, 1'b0);
      push_item({2'b01, DW'($urandom)}, 1'b0, 1'b0);
   endtask

   task automatic gen_scenario(input int kind);
      case (kind)
         0: push_good(2'($urandom), 2'($urandom), 8'($urandom), {$urandom, $urandom});
         1: push_misroute();
         2: begin   // short packet
            push_item(head_flit(MX, MY, 2'd3, 2'd3, 8'd1), 1'b0, 1'b0);
            push_item({2'b01, DW'($urandom)}, 1'b1, 1'b0);
         end
         3: push_item({$urandom_range(0, 1) ? 2'b01 : 2'b00, DW'($urandom)}, 1'b1, 1'b0);
         4: begin   // overlength
            push_item(head_flit(MX, MY, 2'd0, 2'd1, 8'd2), 1'b0, 1'b0);
            push_item({2'b00, DW'($urandom)}, 1'b0, 1'b0);
            push_item({2'b00, DW'($urandom)}, 1'b1, 1'b0);
            push_item({2'b01, DW'($urandom)}, 1'b0, 1'b0);
         end
         default: begin   // head inside a packet
            push_item(head_flit(MX, MY, 2'd2, 2'd0, 8'd3), 1'b0, 1'b0);
            push_item({2'b00, DW'($urandom)}, 1'b0, 1'b0);
            push_item(head_flit(2'($urandom), 2'($urandom), 2'd1, 2'd1, 8'd4), 1'b1, 1'b0);
            push_item({2'b00, DW'($urandom)}, 1'b0, 1'b0);
            push_item({2'b01, DW'($urandom)}, 1'b0, 1'b0);
         end
      endcase
   endtask

   task automatic wait_rx_idle();
      int cyc = 0;
      while ((rx_q.size() != 0 || bus.rx_valid || ej_pend) && cyc < 20000) begin
         @(negedge clk);
         cyc++;
      end
      chk("rx_drain_timeout", cyc < 20000, 1'b1);
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_tx_idle();
      int cyc = 0;
      while ((tx_q.size() != 0 || bus.inj_valid) && cyc < 20000) begin
         @(negedge clk);
         cyc++;
      end
      chk("tx_drain_timeout", cyc < 20000, 1'b1);
      repeat (2) @(negedge clk);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // ---------------------------------------------------------------- test sequence
   initial begin
      int acc, low, heads, cyc, e0;
      logic [7:0] last_seq;
      bit done;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_inj_ready", bus.inj_ready, 1'b1);
      chk("rst_tx_valid", bus.tx_valid, 1'b0);
      chk("rst_tx_flit", bus.tx_flit, '0);
      chk("rst_rx_ready", bus.rx_ready, 1'b1);
      chk("rst_ej_valid", bus.ej_valid, 1'b0);
      chk("rst_ej_data", bus.ej_data, '0);
      chk("rst_ej_seq", bus.ej_seq, '0);
      chk("rst_err", bus.err, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Directed inject with tx_ready held high.
      inject(2'd3, 2'd0, {32'hBEEF0002, 32'hCAFE0001});
      @(negedge clk);
      chk("t1_head", bus.tx_flit, 34'h2_0000_C600);
      @(negedge clk);
      chk("t1_body", bus.tx_flit, 34'h0_CAFE_0001);
      @(negedge clk);
      chk("t1_tail", bus.tx_flit, 34'h1_BEEF_0002);
      @(negedge clk);
      chk("t1_inj_ready", bus.inj_ready, 1'b1);
      chk("t1_tx_valid", bus.tx_valid, 1'b0);

      // Head stalled by the router for three cycles.
      tx_mode = 1;
      repeat (2) @(negedge clk);
      inject(2'd3, 2'd0, {32'hBEEF0002, 32'hCAFE0001});
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t2_head_hold", bus.tx_flit, 34'h2_0000_C601);
         chk("t2_valid_hold", bus.tx_valid, 1'b1);
      end
      tx_mode = 2;
      cyc = 0;
      while (!(bus.tx_valid && bus.tx_ready) && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      @(negedge clk);
      chk("t2_body", bus.tx_flit, 34'h0_CAFE_0001);
      wait_tx_idle();

      // 257 back-to-back messages from a fresh sequence counter.
      do_reset();
      @(posedge clk);
      #1;
      bus.inj_valid = 1'b1;
      bus.inj_dst_x = 2'd0;
      bus.inj_dst_y = 2'd3;
      bus.inj_data  = {$urandom, $urandom};
      acc = 0; low = 0; heads = 0; cyc = 0; done = 1'b0; last_seq = 8'hff;
      while (!done && cyc < 5000) begin
         @(negedge clk);
         cyc++;
         if (bus.tx_valid && bus.tx_ready && bus.tx_flit[FW-1 -: 2] == 2'b10) begin
            heads++;
            last_seq = bus.tx_flit[7:0];
         end
         if (bus.inj_ready) begin
            if (bus.inj_valid) begin
               acc++;
               @(posedge clk);
               #1;
               bus.inj_data = {$urandom, $urandom};
               if (acc == 257) bus.inj_valid = 1'b0;
            end else begin
               done = 1'b1;
            end
         end else begin
            low++;
         end
      end
      chk("b2b_accepts", acc, 257);
      chk("b2b_heads", heads, 257);
      chk("b2b_ready_low_cycles", low, 257 * 3);
      chk("b2b_last_seq_wrap", last_seq, 8'h00);
      wait_tx_idle();

      // Good packet for this node, ejection stalled for five cycles.
      ej_mode = 1;
      push_good(2'd0, 2'd3, 8'd7, 64'h2222_2222_1111_1111);
      cyc = 0;
      while (!bus.ej_valid && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      chk("rx1_ej_src_x", bus.ej_src_x, 2'd0);
      chk("rx1_ej_src_y", bus.ej_src_y, 2'd3);
      chk("rx1_ej_seq", bus.ej_seq, 8'd7);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("rx1_hold_rx_ready", bus.rx_ready, 1'b0);
         chk("rx1_hold_data", bus.ej_data, 64'h2222_2222_1111_1111);
      end
      ej_mode = 2;
      wait_rx_idle();

      // Misrouted head followed by a good packet.
      e0 = err_seen;
      push_misroute();
      push_good(2'd2, 2'd1, 8'd9, {$urandom, $urandom});
      wait_rx_idle();
      chk("misroute_err_pulses", err_seen - e0, 1);

      // Tail directly after head.
      e0 = err_seen;
      gen_scenario(2);
      wait_rx_idle();
      chk("short_err_pulses", err_seen - e0, 1);

      // Body without a head.
      e0 = err_seen;
      push_item({2'b00, 32'h1234_5678}, 1'b1, 1'b0);
      wait_rx_idle();
      chk("orphan_err_pulses", err_seen - e0, 1);

      // Reset while a packet is half received; the next packet must start cleanly.
      push_item(head_flit(MX, MY, 2'd1, 2'd1, 8'd5), 1'b0, 1'b0);
      push_item({2'b00, 32'hAAAA_5555}, 1'b0, 1'b0);
      wait_rx_idle();
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rstbody_rx_ready", bus.rx_ready, 1'b1);
      chk("rstbody_ej_valid", bus.ej_valid, 1'b0);
      chk("rstbody_ej_data", bus.ej_data, '0);
      e0 = err_seen;
      push_good(2'd3, 2'd2, 8'd11, {$urandom, $urandom});
      wait_rx_idle();
      chk("rstbody_err_pulses", err_seen - e0, 0);

      // Concurrent randomized traffic on both paths.
      tx_mode = 0;
      ej_mode = 0;
      rx_gaps = 1'b1;
      fork
         begin
            for (int i = 0; i < 150; i++) begin
               repeat ($urandom_range(0, 3)) @(posedge clk);
               inject(2'($urandom), 2'($urandom), {$urandom, $urandom});
            end
         end
         begin
            for (int i = 0; i < 150; i++) gen_scenario(int'($urandom_range(0, 5)));
         end
      join
      wait_tx_idle();
      wait_rx_idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/noc_local_ni.md
Name: noc_local_ni

Overview:
- Network interface that sits on one local port of the 4x4 mesh, between a processing core and its router's L port.
- Injection path: takes one message from the core and serializes it into a head flit plus PAYLOAD_FLITS body flits, the last body flit marked as tail. Flits go to the router's local input.
- Ejection path: accepts flits from the router's local output, checks the destination, reassembles the payload, and presents the message to the core under valid/ready.

Parameters:
- XCOORD, 0, mesh column of this node (0-3); used as the source field and for the destination check.
- YCOORD, 0, mesh row of this node (0-3).
- DATA_W, 32, flit payload width; must be >= 16.
- PAYLOAD_FLITS, 2, body flits per packet; must be >= 1.
- FLIT_W, DATA_W+2, flit width = {type[1:0], data[DATA_W-1:0]}.

Ports:
- clk  in  1  clock (control.clk)
- rst  in  1  synchronous, active-high reset
- inj_valid  in  1  core offers a message
- inj_ready  out  1  NI accepts the message this cycle
- inj_dst_x  in  2  destination column
- inj_dst_y  in  2  destination row
- inj_data  in  PAYLOAD_FLITS*DATA_W  payload; word 0 = LSBs, sent first
- tx_flit  out  FLIT_W  flit to the router L input
- tx_valid  out  1  tx_flit valid
- tx_ready  in  1  router accepts the flit
- rx_flit  in  FLIT_W  flit from the router L output
- rx_valid  in  1  rx_flit valid
- rx_ready  out  1  NI accepts the flit
- ej_valid  out  1  reassembled message available
- ej_ready  in  1  core takes the message
- ej_src_x  out  2  source column of the ejected message
- ej_src_y  out  2  source row of the ejected message
- ej_seq  out  8  source sequence number
- ej_data  out  PAYLOAD_FLITS*DATA_W  reassembled payload
- err  out  1  one-cycle pulse on a protocol or routing error

Behaviour:
- Flit type codes: 2'b10 head, 2'b00 body, 2'b01 tail.
- Head data layout: [15:14] dst_x, [13:12] dst_y, [11:10] src_x, [9:8] src_y, [7:0] seq; all upper bits zero.
- Handshakes: a transfer occurs on valid&&ready in the same cycle. Once asserted, tx_valid and tx_flit stay stable until accepted.
- Reset values: state IDLE/R_HEAD; tx_valid=0, tx_flit=0, inj_ready=1, rx_ready=1, ej_valid=0, ej_* =0, err=0, tx seq=0.
- TX FSM states: IDLE, HEAD, BODY.
  - inj_ready = (state==IDLE).
  - Accept in cycle N: latch dst and data, go to HEAD. The head flit is valid in cycle N+1 and carries the current seq.
  - HEAD→BODY on handshake; beat counter = 0.
  - BODY sends word[cnt]. Type is tail when cnt==PAYLOAD_FLITS-1, otherwise body. cnt increments on each handshake.
  - On the tail handshake: go to IDLE and increment seq, 8-bit wrap (255→0).
  - Minimum packet spacing is PAYLOAD_FLITS+2 cycles (one idle bubble).
  - Destination equal to own coordinates is legal; the router loops it back.
- RX FSM states: R_HEAD, R_BODY, R_HOLD, R_DROP. rx_ready = (state!=R_HOLD).
- R_HEAD:
  - Head with dst==(XCOORD,YCOORD): latch src and seq, cnt=0, go to R_BODY.
  - Head with any other dst: err, go to R_DROP.
  - Body or tail flit: err, discard, stay in R_HEAD.
- R_BODY:
  - Body flit with cnt<PAYLOAD_FLITS-1: store word[cnt], increment cnt.
  - Body flit with cnt==PAYLOAD_FLITS-1 (overlength): err, go to R_DROP.
  - Tail flit with cnt==PAYLOAD_FLITS-1: store, go to R_HOLD.
  - Tail flit with any other cnt (short packet): err, go to R_HEAD.
  - Head flit: err, partial packet and the new head are both discarded, go to R_DROP.
- R_DROP: consume and discard flits until a tail, then go to R_HEAD. No further err pulses.
- R_HOLD:
  - ej_valid=1, with ej_* stable.
  - On ej_ready: ej_valid=0 next cycle, go to R_HEAD.
  - Minimum ejection latency: ej_valid rises in the cycle after the tail handshake.
- err is registered and pulses one cycle after the offending flit handshake. A single flit produces at most one pulse.
- Reset mid-packet: both FSMs abort immediately; partial data is discarded; seq returns to 0.
- TX and RX are fully independent; simultaneous inject and eject impose no ordering.

Test Plan:
- Node (1,2), PAYLOAD_FLITS=2: inject dst(3,0), data {0xBEEF0002,0xCAFE0001}, tx_ready=1.
  → head 0x2_0000_C600 at N+1, body 0x0_CAFE0001 at N+2, tail 0x1_BEEF0002 at N+3, inj_ready high at N+4.
- Same inject with tx_ready low for 3 cycles during the head.
  → tx_flit and tx_valid are held constant; the body follows only after the handshake.
- 257 back-to-back injections.
  → seq fields run 0..255 then 0; inj_ready is low exactly 3 cycles per message.
- RX, node (1,2): head dst(1,2) src(0,3) seq 7, then body and tail.
  → ej_valid in the cycle after the tail, ej_src=(0,3), ej_seq=7, payload correct.
  → hold ej_ready=0 for 5 cycles: rx_ready=0 and ej_* stable throughout.
- RX head with dst(2,2).
  → err pulses once; the following body and tail are consumed silently; the next good packet is ejected normally.
- RX errors:
  - Tail right after the head: err, FSM returns to R_HEAD.
  - Body with no preceding head: err, flit discarded.
  - rst asserted in R_BODY: next cycle rx_ready=1, ej_valid=0, state R_HEAD.
